mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares the single byte-wide RAM/IO port between two requesters: instruction fetch (word reads) and the memory operator (byte/half/word loads and stores dispatched by the central schedule unit).
Serialises each request into per-byte RAM cycles and assembles read bytes into a little-endian word.
Arbitrates round-robin, aborts reads on pipeline flush, and holds IO-space writes while the IO buffer is full.

Parameters:
ADDR_WIDTH, 32, requester and RAM address width
IO_ADDR_BASE, 32'h00030000, addresses with addr[17:16]==2'b11 are IO space; only writes are stalled by io_buffer_full

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-high reset
rdy_in  input  1  global ready; when low, all state freezes
flush_pipline  input  1  flush from commit; aborts read transactions
if_req  input  1  fetch request, held high until if_done
if_addr  input  ADDR_WIDTH  fetch word address
if_done  output  1  one-cycle pulse; if_rdata valid
if_rdata  output  32  fetched word
mo_req  input  1  memory-operator request, held until mo_done
mo_we  input  1  1 = store, 0 = load
mo_size  input  2  0 = byte, 1 = half, 2 = word (3 treated as word)
mo_addr  input  ADDR_WIDTH  byte address
mo_wdata  input  32  store data, low bytes used
mo_done  output  1  one-cycle pulse; mo_rdata valid for loads
mo_rdata  output  32  zero-extended load data (sign extension done by memory operator)
mem_din  input  8  RAM read byte (1-cycle latency)
mem_dout  output  8  RAM write byte
mem_a  output  ADDR_WIDTH  RAM address
mem_wr  output  1  1 = write
io_buffer_full  input  1  IO output buffer full

Behaviour:
- States: IDLE, READ, WRITE, DONE. Registers: owner (0 = fetch, 1 = mo), base address, byte count N (1/2/4), issue counter, receive counter, assembled data, last_grant.
- Reset: state IDLE; if_done = mo_done = 0; mem_wr = 0; mem_a = 0; mem_dout = 0; if_rdata = mo_rdata = 0; last_grant = 1, so fetch wins the first tie.
- rdy_in low: no register changes; mem_wr forced 0.
- IDLE: grant a single pending request.
  - Both pending: grant the requester that was not last_grant.
  - Request fields are latched on the granting edge.
  - A mo store goes to WRITE; any other request goes to READ.
- READ:
  - Cycle k (k = 0..N-1 after grant) drives mem_a = base + k.
  - Byte k is sampled from mem_din at the end of cycle k+1 into bits [8k+7:8k].
  - After byte N-1 is captured, go to DONE.
  - Bytes above N are 0.
- WRITE:
  - Cycle k drives mem_a = base + k, mem_dout = wdata byte k, mem_wr = 1.
  - If the address is in IO space and io_buffer_full = 1, that cycle has mem_wr = 0 and k does not advance.
  - After byte N-1 is written, go to DONE.
- DONE:
  - Asserts the owner's done for exactly one cycle; rdata is registered and stays stable until the next done for that port.
  - No grant is made in DONE.
  - Next state IDLE; the requester drops or replaces req at the end of DONE.
- Latency, no stalls: READ grant → done in cycle N+1 after the grant edge; WRITE grant → done in cycle N.
- Address arithmetic: base + k is mod 2^ADDR_WIDTH (wraps).
- Flush:
  - In READ (either owner), go to IDLE next cycle with no done pulse; an in-flight byte is discarded.
  - Flush in WRITE has no effect; the store completes.
  - Flush in DONE suppresses a read done pulse but not a write done pulse.
  - Flush in IDLE blocks the grant that cycle.
- mem_a/mem_dout hold their last values when idle, with mem_wr = 0.
- Reset mid-transaction: next cycle is IDLE, mem_wr = 0, no done pulse.

Decomposition:
- Shared package holds:
  - size encodings SZ_BYTE = 0, SZ_HALF = 1, SZ_WORD = 2;
  - state enum ARB_IDLE/ARB_READ/ARB_WRITE/ARB_DONE;
  - owner codes OWN_IF = 0, OWN_MO = 1;
  - the IO-space match function.
- Single module; no sub-module is warranted.

Test Plan:
- if_req at 0x1000, RAM bytes 13,00,50,00 → mem_a 0x1000..0x1003 on consecutive cycles; if_done in cycle 5 after grant with if_rdata = 0x00500013; mo_done stays 0.
- if_req and mo_req (load byte at 0x2000 = 0xFF) raised in the same IDLE cycle after reset → fetch is served first. mo is granted at the next IDLE and returns mo_rdata = 0x000000FF. A subsequent simultaneous request is granted to fetch.
- Half store 0xABCD to 0x30000 with io_buffer_full high for 3 cycles → mem_wr = 0 during those cycles. Writes are then 0xCD at 0x30000 and 0xAB at 0x30001; mo_done asserts once.
- flush_pipline during byte 2 of a fetch → no if_done; IDLE next cycle. A new if_req at 0x2000 is served with correct data.
- rdy_in low for 2 cycles mid word load → mem_wr = 0 and no counter advance; the result equals the unstalled result (plus 2 cycles of latency, with the RAM model also frozen).
- rst_in asserted mid word store after 2 bytes → mem_wr = 0 next cycle; no mo_done; state IDLE.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the byte-wide memory port arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mem_port_arbiter_pkg;

    // mo_size encodings; 2'd3 falls through to a word access.
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_READ  = 2'd1,
        ARB_WRITE = 2'd2,
        ARB_DONE  = 2'd3
    } arb_state_t;

    // Transaction owner codes, also used for the round-robin history bit.
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_MO = 1'b1;

    // IO space is selected by address bits [17:16] alone.
    function automatic logic is_io_addr(input logic [1:0] addr_hi, input logic [1:0] io_hi);
        return addr_hi == io_hi;
    endfunction

    // Number of RAM byte cycles needed for an access size.
    function automatic logic [2:0] size_to_len(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            SZ_WORD: return 3'd4;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [1:0] idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one byte-wide RAM/IO port between fetch and the memory operator.
// Latency: read done N+1 cycles after the grant edge, write done N cycles after (N = 1/2/4 bytes).
// Backpressure: rdy_in low freezes all state; IO-space writes hold while io_buffer_full is high.
//
// Ports:
//   clk_in, rst_in (sync, active high), rdy_in (global freeze), flush_pipline (aborts reads)
//   if_req/if_addr -> if_done/if_rdata            : instruction fetch, always a word read
//   mo_req/mo_we/mo_size/mo_addr/mo_wdata -> mo_done/mo_rdata : loads and stores
//   mem_din (1-cycle read latency), mem_dout, mem_a, mem_wr   : RAM/IO port
//   io_buffer_full                                : stalls IO-space writes
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int          ADDR_WIDTH   = 32,
    parameter logic [31:0] IO_ADDR_BASE = 32'h0003_0000
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  flush_pipline,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_done,
    output logic [31:0]           if_rdata,
    input  logic                  mo_req,
    input  logic                  mo_we,
    input  logic [1:0]            mo_size,
    input  logic [ADDR_WIDTH-1:0] mo_addr,
    input  logic [31:0]           mo_wdata,
    output logic                  mo_done,
    output logic [31:0]           mo_rdata,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    input  logic                  io_buffer_full
);

    arb_state_t state_q, state_d;

    logic                  owner_q;
    logic                  we_q;
    logic                  last_grant_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] mem_a_q;
    logic [7:0]            mem_dout_q;
    logic [2:0]            len_q;
    logic [2:0]            iss_q;      // addresses issued so far (read) / current byte (write)
    logic [2:0]            rcv_q;      // bytes captured so far (read)
    logic [2:0]            iss_inc;
    logic [31:0]           wdata_q;
    logic [31:0]           asm_q;
    logic [31:0]           asm_next;

    logic grant_if;
    logic grant_mo;
    logic grant_any;
    logic wr_stall;
    logic rd_pend;
    logic rd_last;
    logic wr_last;
    logic done_fire;

    // A tie goes to whichever side did not win last time; flush blocks any grant.
    assign grant_if  = (state_q == ARB_IDLE) && !flush_pipline && if_req &&
                       (!mo_req || (last_grant_q == OWN_MO));
    assign grant_mo  = (state_q == ARB_IDLE) && !flush_pipline && mo_req &&
                       (!if_req || (last_grant_q == OWN_IF));
    assign grant_any = grant_if || grant_mo;

    assign wr_stall = io_buffer_full && is_io_addr(mem_a_q[17:16], IO_ADDR_BASE[17:16]);

    // With 1-cycle RAM latency a byte is in flight whenever more addresses were
    // issued than bytes captured; the final capture ends the read.
    assign rd_pend = (iss_q != rcv_q);
    assign rd_last = rd_pend && (rcv_q == (len_q - 3'd1));
    assign wr_last = (iss_q == (len_q - 3'd1));
    assign iss_inc = iss_q + 3'd1;

    always_comb begin
        asm_next = asm_q;
        asm_next[{rcv_q[1:0], 3'b000} +: 8] = mem_din;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= ARB_IDLE;
        end else if (rdy_in) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mem_wr    = 1'b0;
        done_fire = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (grant_if) begin
                    state_d = ARB_READ;
                end else if (grant_mo) begin
                    state_d = mo_we ? ARB_WRITE : ARB_READ;
                end
            end
            ARB_READ: begin
                if (flush_pipline) begin
                    state_d = ARB_IDLE;
                end else if (rd_last) begin
                    state_d = ARB_DONE;
                end
            end
            ARB_WRITE: begin
                mem_wr = rdy_in && !wr_stall;
                if (!wr_stall && wr_last) begin
                    state_d = ARB_DONE;
                end
            end
            ARB_DONE: begin
                state_d = ARB_IDLE;
                // Gated by rdy_in so a frozen DONE still yields a single pulse.
                // A flush only cancels read completions; stores are already committed.
                done_fire = rdy_in && !(flush_pipline && !we_q);
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign if_done  = done_fire && (owner_q == OWN_IF);
    assign mo_done  = done_fire && (owner_q == OWN_MO);
    assign mem_a    = mem_a_q;
    assign mem_dout = mem_dout_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            owner_q      <= OWN_IF;
            we_q         <= 1'b0;
            last_grant_q <= OWN_MO;
            base_q       <= '0;
            mem_a_q      <= '0;
            mem_dout_q   <= '0;
            len_q        <= '0;
            iss_q        <= '0;
            rcv_q        <= '0;
            wdata_q      <= '0;
            asm_q        <= '0;
            if_rdata     <= '0;
            mo_rdata     <= '0;
        end else if (rdy_in) begin
            case (state_q)
                ARB_IDLE: begin
                    if (grant_any) begin
                        owner_q      <= grant_mo;
                        last_grant_q <= grant_mo;
                        we_q         <= grant_mo && mo_we;
                        base_q       <= grant_mo ? mo_addr : if_addr;
                        mem_a_q      <= grant_mo ? mo_addr : if_addr;
                        len_q        <= grant_mo ? size_to_len(mo_size) : 3'd4;
                        wdata_q      <= mo_wdata;
                        iss_q        <= '0;
                        rcv_q        <= '0;
                        asm_q        <= '0;
                        if (grant_mo && mo_we) begin
                            mem_dout_q <= mo_wdata[7:0];
                        end
                    end
                end
                ARB_READ: begin
                    if (!flush_pipline) begin
                        if (rd_pend) begin
                            asm_q <= asm_next;
                            rcv_q <= rcv_q + 3'd1;
                        end
                        if (rd_last) begin
                            if (owner_q == OWN_MO) begin
                                mo_rdata <= asm_next;
                            end else begin
                                if_rdata <= asm_next;
                            end
                        end
                        // The last address stays on the bus while its byte returns.
                        if (iss_q != len_q) begin
                            iss_q <= iss_inc;
                            if (iss_inc != len_q) begin
                                mem_a_q <= base_q + ADDR_WIDTH'(iss_inc);
                            end
                        end
                    end
                end
                ARB_WRITE: begin
                    if (!wr_stall && !wr_last) begin
                        iss_q      <= iss_inc;
                        mem_a_q    <= base_q + ADDR_WIDTH'(iss_inc);
                        mem_dout_q <= get_byte(wdata_q, iss_inc[1:0]);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic.
// Latency: n/a.
// Backpressure: randomizes rdy_in, io_buffer_full and flush_pipline.
module tb_mem_port_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, flush_pipline;
    logic        if_req, if_done;
    logic [31:0] if_addr, if_rdata;
    logic        mo_req, mo_we, mo_done;
    logic [1:0]  mo_size;
    logic [31:0] mo_addr, mo_wdata, mo_rdata;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr, io_buffer_full;

    always #5 clk_in = ~clk_in;

    mem_port_arbiter #(.ADDR_WIDTH(32), .IO_ADDR_BASE(32'h0003_0000)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_pipline(flush_pipline),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .mo_req(mo_req), .mo_we(mo_we), .mo_size(mo_size), .mo_addr(mo_addr),
        .mo_wdata(mo_wdata), .mo_done(mo_done), .mo_rdata(mo_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h expected=%h", name, act, exp);
    endtask

    // Sparse RAM; unwritten bytes read as a fixed function of their address.
    logic [7:0] ram [logic [31:0]];

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] base, input int n);
        logic [31:0] w = '0;
        for (int i = 0; i < n; i++) w[8*i +: 8] = ram_rd(base + 32'(i));
        return w;
    endfunction

    // RAM with one cycle of read latency; it freezes together with rdy_in.
    always @(posedge clk_in) begin
        if (rdy_in) begin
            if (mem_wr) ram[mem_a] = mem_dout;
            mem_din <= ram_rd(mem_a);
        end
    end

    // Transaction-level reference: phase 0 idle, 1 read, 2 write, 3 done.
    // m_t counts elapsed read cycles or completed write bytes since the grant.
    int          m_ph, m_t, m_n;
    logic        m_lg, m_own, m_we;
    logic [31:0] m_base, m_wd, m_a;
    logic [7:0]  m_dout;
    logic        en_cmp = 1'b0;

    always @(posedge clk_in) begin
        if (rst_in) begin
            m_ph = 0; m_lg = 1'b1; m_a = '0; m_dout = '0;
        end else if (rdy_in) begin
            case (m_ph)
                0: if (!flush_pipline && (if_req || mo_req)) begin
                    m_own  = mo_req && (!if_req || !m_lg);
                    m_lg   = m_own;
                    m_we   = m_own && mo_we;
                    m_base = m_own ? mo_addr : if_addr;
                    m_n    = !m_own ? 4 : (mo_size == 2'd0) ? 1 : (mo_size == 2'd1) ? 2 : 4;
                    m_wd   = mo_wdata;
                    m_t    = 0;
                    m_ph   = m_we ? 2 : 1;
                end
                1: if (flush_pipline) m_ph = 0;
                   else if (m_t == m_n) m_ph = 3;
                   else m_t++;
                2: if (!(m_a[17:16] == 2'b11 && io_buffer_full)) begin
                    if (m_t == m_n - 1) m_ph = 3;
                    else m_t++;
                end
                default: m_ph = 0;
            endcase
            if (m_ph == 1) m_a = m_base + 32'((m_t < m_n) ? m_t : m_n - 1);
            if (m_ph == 2) begin
                m_a    = m_base + 32'(m_t);
                m_dout = m_wd[8*m_t +: 8];
            end
        end
    end

    always @(negedge clk_in) begin
        if (en_cmp) begin
            logic exp_wr, dfire;
            exp_wr = (m_ph == 2) && rdy_in && !(m_a[17:16] == 2'b11 && io_buffer_full);
            dfire  = (m_ph == 3) && rdy_in && !(flush_pipline && !m_we);
            check("mem_wr", 32'(mem_wr), 32'(exp_wr));
            check("mem_a", mem_a, m_a);
            check("mem_dout", 32'(mem_dout), 32'(m_dout));
            check("if_done", 32'(if_done), 32'(dfire && !m_own));
            check("mo_done", 32'(mo_done), 32'(dfire && m_own));
            if (dfire && !m_we) begin
                if (m_own) check("mo_rdata", mo_rdata, exp_word(m_base, m_n));
                else       check("if_rdata", if_rdata, exp_word(m_base, m_n));
            end
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Steps until the wanted done pulses are seen (or max cycles); cycle 0 is the
    // first cycle after the grant edge. Each requester drops req in its done cycle.
    task automatic wait_done(input bit want_if, input bit want_mo, input int max,
                             output int ci, output int cm,
                             output logic [31:0] ri, output logic [31:0] rm);
        ci = -1; cm = -1; ri = '0; rm = '0;
        for (int c = 0; c < max; c++) begin
            step();
            #3;
            if (if_done && ci < 0) begin ci = c; ri = if_rdata; if_req = 1'b0; end
            if (mo_done && cm < 0) begin cm = c; rm = mo_rdata; mo_req = 1'b0; end
            if ((!want_if || ci >= 0) && (!want_mo || cm >= 0)) break;
        end
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom % 4)
            0: return $urandom & 32'h0000_3FFF;
            1: return 32'h0003_0000 | ($urandom & 32'h0000_00FF);
            2: return 32'hFFFF_FFFC | ($urandom % 4);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int ci, cm, nd, nwr, n_if, n_mo;
        logic [31:0] ri, rm;

        rst_in = 1'b1; rdy_in = 1'b1; flush_pipline = 1'b0; io_buffer_full = 1'b0;
        if_req = 1'b0; if_addr = '0; mo_req = 1'b0; mo_we = 1'b0; mo_size = '0;
        mo_addr = '0; mo_wdata = '0;
        ram[32'h1000] = 8'h13; ram[32'h1001] = 8'h00; ram[32'h1002] = 8'h50; ram[32'h1003] = 8'h00;
        ram[32'h2000] = 8'hFF; ram[32'h2001] = 8'h11; ram[32'h2002] = 8'h22; ram[32'h2003] = 8'h33;
        step();
        en_cmp = 1'b1;
        step();
        step();
        rst_in = 1'b0;
        #3;
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_mo_rdata", mo_rdata, 32'h0);
        check("rst_mem_a", mem_a, 32'h0);
        check("rst_mem_dout", 32'(mem_dout), 32'h0);
        check("rst_mem_wr", 32'(mem_wr), 32'h0);
        check("rst_dones", 32'({if_done, mo_done}), 32'h0);

        // Simultaneous requests right after reset: fetch first, then the byte load.
        step();
        if_addr = 32'h1000; if_req = 1'b1;
        mo_addr = 32'h2000; mo_we = 1'b0; mo_size = 2'd0; mo_req = 1'b1;
        wait_done(1'b1, 1'b1, 40, ci, cm, ri, rm);
        check("arb1_if_cycle", 32'(ci), 32'd5);
        check("arb1_mo_cycle", 32'(cm), 32'd9);
        check("arb1_if_rdata", ri, 32'h0050_0013);
        check("arb1_mo_rdata", rm, 32'h0000_00FF);
        step();
        if_addr = 32'h2000; if_req = 1'b1;
        mo_addr = 32'h1000; mo_size = 2'd0; mo_req = 1'b1;
        wait_done(1'b1, 1'b1, 40, ci, cm, ri, rm);
        check("arb2_fetch_first", 32'(ci >= 0 && ci < cm), 32'd1);
        check("arb2_if_rdata", ri, 32'h3322_11FF);

        // Word fetch: consecutive addresses, done five cycles after the grant.
        step();
        if_addr = 32'h1000; if_req = 1'b1;
        ci = -1;
        for (int c = 0; c < 12 && ci < 0; c++) begin
            step();
            #3;
            if (c < 4) check($sformatf("fetch_mem_a%0d", c), mem_a, 32'h1000 + 32'(c));
            if (if_done) begin
                ci = c;
                check("fetch_if_rdata", if_rdata, 32'h0050_0013);
                if_req = 1'b0;
            end
        end
        check("fetch_done_cycle", 32'(ci), 32'd5);

        // Half store into IO space with the IO buffer full for the first 3 cycles.
        step();
        mo_req = 1'b1; mo_we = 1'b1; mo_size = 2'd1; mo_addr = 32'h0003_0000;
        mo_wdata = 32'h1234_ABCD; io_buffer_full = 1'b1;
        nd = 0; nwr = 0;
        for (int c = 0; c < 16; c++) begin
            step();
            if (c == 3) io_buffer_full = 1'b0;
            #3;
            if (c < 3) check($sformatf("io_stall%0d", c), 32'(mem_wr), 32'h0);
            if (mem_wr) nwr++;
            if (mo_done) begin nd++; mo_req = 1'b0; end
        end
        check("io_write_count", 32'(nwr), 32'd2);
        check("io_done_count", 32'(nd), 32'd1);
        check("io_byte0", 32'(ram_rd(32'h0003_0000)), 32'h0000_00CD);
        check("io_byte1", 32'(ram_rd(32'h0003_0001)), 32'h0000_00AB);

        // Flush during byte 2 of a fetch; the replacement fetch at 0x2000 is served.
        step();
        mo_we = 1'b0;
        if_addr = 32'h1000; if_req = 1'b1;
        nd = 0; ci = -1; ri = '0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (c == 2) begin flush_pipline = 1'b1; if_addr = 32'h2000; end
            else flush_pipline = 1'b0;
            #3;
            if (if_done) begin nd++; ci = c; ri = if_rdata; if_req = 1'b0; end
        end
        check("flush_done_count", 32'(nd), 32'd1);
        check("flush_refetch_cycle", 32'(ci), 32'd9);
        check("flush_refetch_rdata", ri, 32'h3322_11FF);

        // Word load with rdy_in low for two cycles in the middle.
        step();
        mo_req = 1'b1; mo_we = 1'b0; mo_size = 2'd2; mo_addr = 32'h1000;
        cm = -1; rm = '0;
        for (int c = 0; c < 20 && cm < 0; c++) begin
            step();
            rdy_in = !(c == 2 || c == 3);
            #3;
            if (c == 2 || c == 3) check($sformatf("frz_mem_wr%0d", c), 32'(mem_wr), 32'h0);
            if (mo_done) begin cm = c; rm = mo_rdata; mo_req = 1'b0; end
        end
        check("frz_done_cycle", 32'(cm), 32'd7);
        check("frz_rdata", rm, 32'h0050_0013);

        // Reset after two bytes of a word store.
        step();
        mo_req = 1'b1; mo_we = 1'b1; mo_size = 2'd2; mo_addr = 32'h0000_4000;
        mo_wdata = 32'hDEAD_BEEF;
        step(); step();
        step();
        rst_in = 1'b1; mo_req = 1'b0;
        step();
        rst_in = 1'b0;
        #3;
        check("rst_mid_mem_wr", 32'(mem_wr), 32'h0);
        check("rst_mid_mo_done", 32'(mo_done), 32'h0);
        check("rst_mid_mem_a", mem_a, 32'h0);
        check("rst_mid_byte0", 32'(ram_rd(32'h4000)), 32'h0000_00EF);
        check("rst_mid_byte1", 32'(ram_rd(32'h4001)), 32'h0000_00BE);
        if_addr = 32'h1000; if_req = 1'b1;
        wait_done(1'b1, 1'b0, 20, ci, cm, ri, rm);
        check("rst_mid_idle_fetch", 32'(ci), 32'd5);

        // Randomized traffic; the reference model checks every cycle.
        n_if = 0; n_mo = 0;
        for (int c = 0; c < 3000; c++) begin
            step();
            rdy_in         = ($urandom % 8) != 0;
            io_buffer_full = ($urandom % 3) == 0;
            flush_pipline  = ($urandom % 16) == 0;
            if (!if_req && ($urandom % 2) == 1) begin
                if_req = 1'b1; if_addr = rand_addr();
            end
            if (!mo_req && ($urandom % 2) == 1) begin
                mo_req = 1'b1; mo_addr = rand_addr(); mo_we = 1'($urandom % 2);
                mo_size = 2'($urandom % 4); mo_wdata = $urandom;
            end
            #3;
            if (if_done) begin if_req = 1'b0; n_if++; end
            if (mo_done) begin mo_req = 1'b0; n_mo++; end
        end
        step();
        rdy_in = 1'b1; flush_pipline = 1'b0; io_buffer_full = 1'b0;
        for (int c = 0; c < 60 && (if_req || mo_req); c++) begin
            step();
            #3;
            if (if_done) begin if_req = 1'b0; n_if++; end
            if (mo_done) begin mo_req = 1'b0; n_mo++; end
        end
        check("rand_drained", 32'({if_req, mo_req}), 32'h0);
        check("rand_progress", 32'(n_if > 20 && n_mo > 20), 32'd1);

        step();
        step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
